out_port_fifo: RTL and testbench
================================

OUT_PORT_FIFO -- requirements
Module: out_port_fifo

Interface
REQ-001 SHALL have parameter NUBITS, default 16: data word width; equals the processor word size.
REQ-002 SHALL have parameter NUIOOU, default 2: number of processor output ports.
REQ-003 SHALL have parameter FDEPTH, default 8: entry count; power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-006 SHALL have port io_out, input, NUBITS bits: output data word from the processor.
REQ-007 SHALL have port addr_out, input, $clog2(NUIOOU) bits: output port address from the processor.
REQ-008 SHALL have port out_en, input, 1 bit: processor output strobe; one word per high cycle.
REQ-009 SHALL have port m_data, output, NUBITS bits: head entry data.
REQ-010 SHALL have port m_addr, output, $clog2(NUIOOU) bits: head entry port address.
REQ-011 SHALL have port m_valid, output, 1 bit: head entry valid.
REQ-012 SHALL have port m_ready, input, 1 bit: consumer accepts the head entry.
REQ-013 SHALL have port level, output, $clog2(FDEPTH)+1 bits: current occupancy.
REQ-014 SHALL have port full, output, 1 bit: level equals FDEPTH.
REQ-015 SHALL have port ovf, output, 1 bit: sticky overflow flag.
REQ-016 SHALL have port ovf_clr, input, 1 bit: clears ovf.

Function
REQ-017 SHALL push {addr_out, io_out} when out_en=1 and either full=0 or a pop occurs in the same cycle.
REQ-018 SHALL pop when m_valid=1 and m_ready=1; m_ready SHALL be ignored while m_valid=0.
REQ-019 SHALL operate first-word-fall-through: m_data and m_addr are driven combinationally from the head entry; m_valid = (level != 0).
REQ-020 SHALL make a pushed word visible on m_valid/m_data in the cycle after the push edge; push-to-output latency is 1 cycle.
REQ-021 SHALL change level by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-022 SHALL advance the read and write pointers modulo FDEPTH; wrap-around is transparent.
REQ-023 SHALL drop the word when out_en=1, full=1, and there is no same-cycle pop, and set ovf=1 on that edge.
REQ-024 SHALL clear ovf when ovf_clr=1 and no drop occurs in that cycle; a drop SHALL win over ovf_clr.
REQ-025 SHALL accept a simultaneous push and pop at level=0 as a push only; the pop is invalid because m_valid=0.
REQ-026 SHALL drive m_data and m_addr as don't-care while m_valid=0; the bench SHALL NOT check them.

Reset
REQ-027 SHALL, on rst=1 at a rising edge, clear pointers, level, and ovf; m_valid=0 and full=0 SHALL hold from the next cycle.
REQ-028 SHALL discard in-flight contents on reset mid-operation; push, pop, and ovf_clr are ignored in the reset cycle.
REQ-029 SHALL leave storage contents unreset; the storage is an inferable register array with no reset.

Structure
REQ-030 SHALL use no shared package; all sizes SHALL be module parameters, and widths SHALL be derived with $clog2.
REQ-031 SHALL instantiate no sub-module; the storage SHALL be an inline array of FDEPTH x (NUBITS + $clog2(NUIOOU)) bits.
REQ-032 SHALL attach io_out, addr_out, and out_en directly to the same-named processor ports, with no glue logic.

Verification
REQ-033 SHALL cover single word: push 0x1234 at port 1 with m_ready=0 -> next cycle m_valid=1, m_data=0x1234, m_addr=1, level=1.
REQ-034 SHALL cover fill: 8 pushes of 1..8 with m_ready=0 -> full=1, level=8; a 9th push of 0x00FF -> ovf=1, level=8, drain order 1..8.
REQ-035 SHALL cover full with simultaneous pop: level=8, out_en=1 (0xAAAA), m_ready=1 -> level stays 8, ovf=0, 0xAAAA is the last entry.
REQ-036 SHALL cover wrap-around: 20 pushes of 0..19 with m_ready=1 continuously -> 20 outputs in order, level never exceeds 1, ovf=0.
REQ-037 SHALL cover reset mid-operation: level=5, rst=1 for 1 cycle with out_en=1 -> level=0, m_valid=0, ovf=0; the first push afterwards appears unchanged.
REQ-038 SHALL cover ovf priority: ovf_clr=1 in the same cycle as a drop -> ovf=1; ovf_clr=1 in the next cycle with no drop -> ovf=0.

Source files
------------

// File: rtl/out_port_fifo.sv
// Output-port FIFO between the processor's output strobe and a ready/valid consumer.
// First-word-fall-through; words arriving while full are dropped and flagged in a sticky ovf.
module out_port_fifo #(
  parameter int NUBITS = 16,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUBITS-1:0]         io_out,
  input  logic [$clog2(NUIOOU)-1:0] addr_out,
  input  logic                      out_en,
  output logic [NUBITS-1:0]         m_data,
  output logic [$clog2(NUIOOU)-1:0] m_addr,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(FDEPTH):0]   level,
  output logic                      full,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  localparam int AW = $clog2(NUIOOU);
  localparam int PW = $clog2(FDEPTH);
  localparam int LW = PW + 1;
  localparam int EW = NUBITS + AW;

  logic [EW-1:0] mem [FDEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          ovf_reg;
  logic          push, pop, drop;

  assign m_valid = (level_reg != '0);
  assign full    = (level_reg == LW'(FDEPTH));
  assign level   = level_reg;
  assign ovf     = ovf_reg;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign pop  = m_valid & m_ready;
  assign push = out_en & (~full | pop);
  assign drop = out_en & full & ~pop;

  assign {m_addr, m_data} = mem[rd_ptr_reg];

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {addr_out, io_out};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
      // A drop on the same edge as a clear request keeps the flag set.
      if (drop)         ovf_reg <= 1'b1;
      else if (ovf_clr) ovf_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_out_port_fifo.sv
// Bench for out_port_fifo: vector table plus hand sequences, checked against a queue model.
module tb_out_port_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] io_out = '0;
  logic [0:0]  addr_out = '0;
  logic        out_en = 1'b0;
  logic [15:0] m_data;
  logic [0:0]  m_addr;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [3:0]  level;
  logic        full;
  logic        ovf;
  logic        ovf_clr = 1'b0;

  out_port_fifo #(.NUBITS(16), .NUIOOU(2), .FDEPTH(8)) dut (
    .clk(clk), .rst(rst), .io_out(io_out), .addr_out(addr_out), .out_en(out_en),
    .m_data(m_data), .m_addr(m_addr), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .full(full), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        oe;
    logic [15:0] d;
    logic        a;
    logic        rdy;
    logic        clr;
    logic        r;
    int          exp_lvl;
    logic        exp_ovf;
  } vec_t;

  vec_t        vt[$];
  logic [16:0] sb[$];
  logic        m_ovf = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          n_step = 0;
  int          n_pop = 0;

  function automatic vec_t mk(input logic oe, input logic [15:0] d, input logic a,
                              input logic rdy, input logic clr, input logic r,
                              input int exp_lvl, input logic exp_ovf);
    vec_t v;
    v.oe = oe; v.d = d; v.a = a; v.rdy = rdy; v.clr = clr; v.r = r;
    v.exp_lvl = exp_lvl; v.exp_ovf = exp_ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (step %0d)", nm, act, exp, n_step);
    end
  endtask

  // One clock cycle: drive, score any pop against the queue, advance the model, check state.
  task automatic step(input logic oe, input logic [15:0] d, input logic a,
                      input logic rdy, input logic clr, input logic r);
    logic        pop_m, push_m;
    logic [16:0] expv;
    @(negedge clk);
    out_en = oe; io_out = d; addr_out = a; m_ready = rdy; ovf_clr = clr; rst = r;
    #1;
    pop_m  = !r && (sb.size() > 0) && rdy;
    push_m = !r && oe && ((sb.size() < 8) || pop_m);
    if (pop_m) begin
      expv = sb.pop_front();
      n_pop++;
      chk("pop_data", 32'({m_addr, m_data}), 32'(expv));
    end
    if (r) begin
      sb.delete();
      m_ovf = 1'b0;
    end else begin
      if (push_m) sb.push_back({a, d});
      if (oe && !push_m) m_ovf = 1'b1;
      else if (clr)      m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("level", 32'(level), 32'(sb.size()));
    chk("m_valid", 32'(m_valid), 32'(sb.size() != 0));
    chk("full", 32'(full), 32'(sb.size() == 8));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    if (sb.size() > 0) chk("head", 32'({m_addr, m_data}), 32'(sb[0]));
    $display("step %0d oe=%0b d=%h a=%0b rdy=%0b clr=%0b rst=%0b -> level=%0d valid=%0b full=%0b ovf=%0b",
             n_step, oe, d, a, rdy, clr, r, level, m_valid, full, ovf);
    n_step++;
  endtask

  initial begin
    int pops_before;

    // Reset state
    step(0, 16'h0, 0, 0, 0, 1);
    step(0, 16'h0, 0, 0, 0, 1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Single word, fill/overflow, full with pop, drain order, empty push+pop
    vt.push_back(mk(1, 16'h1234, 1, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 8; i++) vt.push_back(mk(1, 16'(i), 1'(i % 2), 0, 0, 0, i, 0));
    vt.push_back(mk(1, 16'h00FF, 0, 0, 0, 0, 8, 1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 8, 0));
    vt.push_back(mk(1, 16'hAAAA, 1, 1, 0, 0, 8, 0));
    for (int i = 7; i >= 0; i--) vt.push_back(mk(0, 16'h0000, 0, 1, 0, 0, i, 0));
    vt.push_back(mk(1, 16'h5555, 0, 1, 0, 0, 1, 0));
    vt.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 0, 0));

    foreach (vt[k]) begin
      step(vt[k].oe, vt[k].d, vt[k].a, vt[k].rdy, vt[k].clr, vt[k].r);
      chk("tbl_level", 32'(level), 32'(vt[k].exp_lvl));
      chk("tbl_ovf", 32'(ovf), 32'(vt[k].exp_ovf));
      if (k == 0) begin
        chk("single_data", 32'(m_data), 32'h1234);
        chk("single_addr", 32'(m_addr), 32'd1);
      end
    end

    // Wrap-around with continuous ready
    pops_before = n_pop;
    for (int i = 0; i < 20; i++) begin
      step(1, 16'(i), 1'(i % 2), 1, 0, 0);
      chk("wrap_level_le1", 32'(level <= 4'd1), 32'd1);
    end
    step(0, 16'h0, 0, 1, 0, 0);
    chk("wrap_pops", 32'(n_pop - pops_before), 32'd20);
    chk("wrap_ovf", 32'(ovf), 32'd0);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) step(1, 16'(16'h100 + i), 0, 0, 0, 0);
    chk("pre_rst_level", 32'(level), 32'd5);
    step(1, 16'h7777, 0, 1, 1, 1);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    step(1, 16'hBEEF, 1, 0, 0, 0);
    chk("post_rst_data", 32'(m_data), 32'hBEEF);
    step(0, 16'h0, 0, 1, 0, 0);

    // Overflow priority over clear
    for (int i = 0; i < 8; i++) step(1, 16'(16'h200 + i), 0, 0, 0, 0);
    step(1, 16'h00FF, 0, 0, 1, 0);
    chk("drop_beats_clr", 32'(ovf), 32'd1);
    step(0, 16'h0, 0, 0, 1, 0);
    chk("clr_after_drop", 32'(ovf), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 16'h0, 0, 1, 0, 0);
    chk("final_empty", 32'(m_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
